eh2_dccm_scrub: RTL and testbench



---
 rtl/eh2_dccm_scrub.sv | 176 +++++++++++++++++
 tb/tb_eh2_dccm_scrub.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_dccm_scrub.sv
// Background DCCM scrubber: walks every word through the lo port, fixes single-bit errors,
// and flags and counts double-bit errors, using only cycles the LSU leaves idle.
module eh2_dccm_scrub #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39
) (
   input  logic                        clk,
   input  logic                        rst_l,
   input  logic                        scrub_en,
   input  logic [15:0]                 scrub_interval,
   input  logic                        lsu_dccm_busy,
   input  logic                        lsu_dccm_wren,
   input  logic [DCCM_BITS-1:0]        lsu_dccm_wr_addr,
   output logic                        scrub_dccm_rden,
   output logic                        scrub_dccm_wren,
   output logic [DCCM_BITS-1:0]        scrub_dccm_addr,
   output logic [DCCM_FDATA_WIDTH-1:0] scrub_dccm_wr_data,
   input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
   output logic                        scrub_sb_err,
   output logic                        scrub_db_err,
   output logic [DCCM_BITS-1:0]        scrub_err_addr,
   output logic [15:0]                 scrub_sb_cnt,
   output logic [15:0]                 scrub_db_cnt,
   output logic                        scrub_pass_done
);

   // state  | meaning
   // IDLE   | disabled, word pointer retained
   // WAIT   | interval down-counter running
   // RD     | read strobe, held while LSU owns the port
   // CHK    | read data decoded
   // WR     | corrected writeback, held while LSU owns the port
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_WR   = 3'd4;

   localparam int WW = DCCM_BITS - 2;

   function automatic logic [6:0] ecc_gen(input logic [31:0] d);
      logic [6:0] e;
      e[0] = ^(d & 32'h56AA_AD5B);
      e[1] = ^(d & 32'h9B33_366D);
      e[2] = ^(d & 32'hE3C3_C78E);
      e[3] = ^(d & 32'h03FC_07F0);
      e[4] = ^(d & 32'h03FF_F800);
      e[5] = ^(d & 32'hFC00_0000);
      e[6] = ^{d, e[5:0]};
      return e;
   endfunction

   // Data bits occupy the non-power-of-two Hamming positions 3..38 in order.
   function automatic logic [31:0] ecc_fix(input logic [31:0] d, input logic [5:0] syn);
      logic [31:0] f;
      logic [4:0]  idx;
      f   = d;
      idx = 5'd0;
      for (int p = 3; p < 39; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (syn == p[5:0]) f[idx] = ~f[idx];
            idx = idx + 5'd1;
         end
      end
      return f;
   endfunction

   logic [2:0]                  state_q;
   logic [15:0]                 cnt_q;
   logic [WW-1:0]               word_q;
   logic [DCCM_BITS-1:0]        word_addr;
   logic [DCCM_FDATA_WIDTH-1:0] wr_data_q;
   logic [DCCM_BITS-1:0]        err_addr_q;
   logic [15:0]                 sb_cnt_q;
   logic [15:0]                 db_cnt_q;
   logic                        sb_err_q;
   logic                        db_err_q;

   logic [31:0] rd_d;
   logic [6:0]  rd_e;
   logic [6:0]  calc_e;
   logic [5:0]  syn;
   logic        sb_hit;
   logic        db_hit;
   logic [31:0] fix_d;
   logic [6:0]  fix_e;
   logic        coll;
   logic        chk_done;
   logic        wr_done;
   logic        advance;
   logic        unused_lsb;

   assign unused_lsb = ^lsu_dccm_wr_addr[1:0];
   assign word_addr  = {word_q, 2'b00};

   always_comb begin
      rd_d     = dccm_rd_data_lo[31:0];
      rd_e     = dccm_rd_data_lo[38:32];
      calc_e   = ecc_gen(rd_d);
      syn      = rd_e[5:0] ^ calc_e[5:0];
      sb_hit   = ^{rd_d, rd_e};
      db_hit   = ~sb_hit & (syn != 6'd0);
      fix_d    = ecc_fix(rd_d, syn);
      fix_e    = ecc_gen(fix_d);
      coll     = lsu_dccm_wren & (lsu_dccm_wr_addr[DCCM_BITS-1:2] == word_q);
      // An LSU write to the same word makes our corrected copy stale, so drop it.
      chk_done = (state_q == S_CHK) & (~sb_hit | coll);
      wr_done  = (state_q == S_WR) & (coll | ~lsu_dccm_busy);
      advance  = chk_done | wr_done;
   end

   assign scrub_dccm_rden    = (state_q == S_RD) & ~lsu_dccm_busy;
   assign scrub_dccm_wren    = (state_q == S_WR) & ~lsu_dccm_busy & ~coll;
   assign scrub_dccm_addr    = word_addr;
   assign scrub_dccm_wr_data = wr_data_q;
   assign scrub_sb_err       = sb_err_q;
   assign scrub_db_err       = db_err_q;
   assign scrub_err_addr     = err_addr_q;
   assign scrub_sb_cnt       = sb_cnt_q;
   assign scrub_db_cnt       = db_cnt_q;
   assign scrub_pass_done    = advance & (&word_q);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         word_q     <= '0;
         wr_data_q  <= '0;
         err_addr_q <= '0;
         sb_cnt_q   <= 16'd0;
         db_cnt_q   <= 16'd0;
         sb_err_q   <= 1'b0;
         db_err_q   <= 1'b0;
      end else begin
         sb_err_q <= 1'b0;
         db_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (scrub_en) begin
                  state_q <= S_WAIT;
                  cnt_q   <= scrub_interval;
               end
            end
            S_WAIT: begin
               if (!scrub_en)           state_q <= S_IDLE;
               else if (cnt_q == 16'd0) state_q <= S_RD;
               else                     cnt_q   <= cnt_q - 16'd1;
            end
            S_RD: begin
               if (!lsu_dccm_busy) state_q <= S_CHK;
            end
            S_CHK: begin
               if (sb_hit) begin
                  sb_err_q   <= 1'b1;
                  err_addr_q <= word_addr;
                  wr_data_q  <= DCCM_FDATA_WIDTH'({fix_e, fix_d});
                  state_q    <= S_WR;
                  if (sb_cnt_q != 16'hFFFF) sb_cnt_q <= sb_cnt_q + 16'd1;
               end else if (db_hit) begin
                  db_err_q   <= 1'b1;
                  err_addr_q <= word_addr;
                  if (db_cnt_q != 16'hFFFF) db_cnt_q <= db_cnt_q + 16'd1;
               end
            end
            S_WR: ;
            default: state_q <= S_IDLE;
         endcase
         if (advance) begin
            word_q  <= word_q + WW'(1);
            cnt_q   <= scrub_interval;
            state_q <= scrub_en ? S_WAIT : S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_eh2_dccm_scrub.sv
// Directed bench for eh2_dccm_scrub on a 16-word DCCM with a behavioural memory model.
module tb_eh2_dccm_scrub;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        scrub_en;
   logic [15:0] scrub_interval;
   logic        lsu_dccm_busy;
   logic        lsu_dccm_wren;
   logic [5:0]  lsu_dccm_wr_addr;
   logic        scrub_dccm_rden;
   logic        scrub_dccm_wren;
   logic [5:0]  scrub_dccm_addr;
   logic [38:0] scrub_dccm_wr_data;
   logic [38:0] dccm_rd_data_lo = '0;
   logic        scrub_sb_err;
   logic        scrub_db_err;
   logic [5:0]  scrub_err_addr;
   logic [15:0] scrub_sb_cnt;
   logic [15:0] scrub_db_cnt;
   logic        scrub_pass_done;

   int n_cmp = 0;
   int n_bad = 0;

   eh2_dccm_scrub #(.DCCM_BITS(6), .DCCM_FDATA_WIDTH(39)) dut (
      .clk                (clk),
      .rst_l              (rst_l),
      .scrub_en           (scrub_en),
      .scrub_interval     (scrub_interval),
      .lsu_dccm_busy      (lsu_dccm_busy),
      .lsu_dccm_wren      (lsu_dccm_wren),
      .lsu_dccm_wr_addr   (lsu_dccm_wr_addr),
      .scrub_dccm_rden    (scrub_dccm_rden),
      .scrub_dccm_wren    (scrub_dccm_wren),
      .scrub_dccm_addr    (scrub_dccm_addr),
      .scrub_dccm_wr_data (scrub_dccm_wr_data),
      .dccm_rd_data_lo    (dccm_rd_data_lo),
      .scrub_sb_err       (scrub_sb_err),
      .scrub_db_err       (scrub_db_err),
      .scrub_err_addr     (scrub_err_addr),
      .scrub_sb_cnt       (scrub_sb_cnt),
      .scrub_db_cnt       (scrub_db_cnt),
      .scrub_pass_done    (scrub_pass_done)
   );

   always #5 clk = ~clk;

   // Hamming(38,32) by position: check bit k covers every position with bit k set, then overall parity.
   function automatic logic [6:0] ecc_model(input logic [31:0] d);
      logic [6:0] e;
      int         i;
      e = '0;
      i = 0;
      for (int p = 3; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            for (int k = 0; k < 6; k++)
               if (p[k]) e[k] = e[k] ^ d[i];
            i++;
         end
      end
      e[6] = ^{d, e[5:0]};
      return e;
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
   endfunction

   logic [38:0] mem [16];
   logic [38:0] wb_mem [16];
   logic [15:0] wb_vld;

   always @(posedge clk) begin
      if (!rst_l) wb_vld <= '0;
      else begin
         if (scrub_dccm_rden)
            dccm_rd_data_lo <= wb_vld[scrub_dccm_addr[5:2]] ? wb_mem[scrub_dccm_addr[5:2]]
                                                          : mem[scrub_dccm_addr[5:2]];
         if (scrub_dccm_wren) begin
            wb_mem[scrub_dccm_addr[5:2]] <= scrub_dccm_wr_data;
            wb_vld[scrub_dccm_addr[5:2]] <= 1'b1;
         end
      end
   end

   int         cyc = 0;
   int         rd_cyc[$];
   logic [5:0] rd_addr[$];
   int         pass_cyc[$];
   logic [5:0] pass_addr[$];
   int         n_wren, n_sb, n_db;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_l) begin
         rd_cyc.delete(); rd_addr.delete(); pass_cyc.delete(); pass_addr.delete();
         n_wren = 0; n_sb = 0; n_db = 0;
      end else begin
         if (scrub_dccm_rden) begin rd_cyc.push_back(cyc); rd_addr.push_back(scrub_dccm_addr); end
         if (scrub_pass_done) begin pass_cyc.push_back(cyc); pass_addr.push_back(scrub_dccm_addr); end
         if (scrub_dccm_wren) n_wren++;
         if (scrub_sb_err) n_sb++;
         if (scrub_db_err) n_db++;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_clean();
      for (int i = 0; i < 16; i++) mem[i] = {ecc_model(pat(i)), pat(i)};
   endtask

   task automatic flip(input int w, input logic [31:0] mask);
      mem[w] = {ecc_model(pat(w)), pat(w) ^ mask};
   endtask

   task automatic do_reset(input logic [15:0] ivl);
      rst_l = 1'b0; scrub_en = 1'b0; lsu_dccm_busy = 1'b0; lsu_dccm_wren = 1'b0;
      lsu_dccm_wr_addr = '0; scrub_interval = ivl;
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b1;
   endtask

   task automatic wait_rd(input logic [5:0] a, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         if (scrub_dccm_rden && scrub_dccm_addr == a) ok = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit         ok;
      int         bad;
      int         k;
      int         n0;
      logic [38:0] exp_wb;

      // Reset values with enable already high.
      load_clean();
      rst_l = 1'b0; scrub_en = 1'b1; scrub_interval = 16'd0; lsu_dccm_busy = 1'b0;
      lsu_dccm_wren = 1'b0; lsu_dccm_wr_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rden",     scrub_dccm_rden, 0);
      check_eq("rst_wren",     scrub_dccm_wren, 0);
      check_eq("rst_addr",     scrub_dccm_addr, 0);
      check_eq("rst_wr_data",  scrub_dccm_wr_data, 0);
      check_eq("rst_sb_err",   scrub_sb_err, 0);
      check_eq("rst_db_err",   scrub_db_err, 0);
      check_eq("rst_err_addr", scrub_err_addr, 0);
      check_eq("rst_sb_cnt",   scrub_sb_cnt, 0);
      check_eq("rst_db_cnt",   scrub_db_cnt, 0);
      check_eq("rst_pass",     scrub_pass_done, 0);
      @(posedge clk);
      #1 rst_l = 1'b1;

      // Clean walk, interval 0.
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (pass_cyc.size() >= 2) ok = 1'b1;
      end
      check_eq("clean_two_passes_seen", ok, 1);
      check_eq("clean_rd_count_ge17", rd_cyc.size() >= 17, 1);
      if (rd_cyc.size() >= 17 && pass_cyc.size() >= 2) begin
         bad = 0;
         for (int i = 0; i < 17; i++) if (rd_addr[i] != 6'((i % 16) * 4)) bad++;
         check_eq("clean_rd_addr_seq", bad, 0);
         bad = 0;
         for (int i = 0; i < 16; i++) if (rd_cyc[i+1] - rd_cyc[i] != 3) bad++;
         check_eq("clean_rd_spacing", bad, 0);
         check_eq("clean_pass_addr", pass_addr[0], 6'h3C);
         check_eq("clean_pass_period", pass_cyc[1] - pass_cyc[0], 48);
      end
      check_eq("clean_sb_pulses", n_sb, 0);
      check_eq("clean_db_pulses", n_db, 0);
      check_eq("clean_wren", n_wren, 0);

      // Interval 2 gives 5 cycles per word.
      do_reset(16'd2);
      scrub_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (rd_cyc.size() >= 2) ok = 1'b1;
      end
      check_eq("ivl2_seen", ok, 1);
      if (ok) check_eq("ivl2_spacing", rd_cyc[1] - rd_cyc[0], 5);

      // Single-bit error at 0x10, data bit 5.
      load_clean();
      flip(4, 32'h0000_0020);
      exp_wb = {ecc_model(pat(4)), pat(4)};
      do_reset(16'd0);
      scrub_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (scrub_sb_err) ok = 1'b1;
      end
      check_eq("sb_seen", ok, 1);
      check_eq("sb_err_addr", scrub_err_addr, 6'h10);
      check_eq("sb_cnt", scrub_sb_cnt, 1);
      check_eq("sb_wren", scrub_dccm_wren, 1);
      check_eq("sb_wr_addr", scrub_dccm_addr, 6'h10);
      check_eq("sb_wr_data", scrub_dccm_wr_data, exp_wb);
      @(negedge clk);
      check_eq("sb_pulse_width", scrub_sb_err, 0);
      wait_rd(6'h10, 80, ok);
      check_eq("sb_reread_seen", ok, 1);
      repeat (3) @(negedge clk);
      check_eq("sb_reread_cnt", scrub_sb_cnt, 1);
      check_eq("sb_reread_wren", n_wren, 1);

      // Double-bit error at 0x20.
      load_clean();
      flip(8, 32'h0002_0008);
      do_reset(16'd0);
      scrub_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (scrub_db_err) ok = 1'b1;
      end
      check_eq("db_seen", ok, 1);
      check_eq("db_err_addr", scrub_err_addr, 6'h20);
      check_eq("db_cnt", scrub_db_cnt, 1);
      check_eq("db_sb_cnt", scrub_sb_cnt, 0);
      repeat (20) @(negedge clk);
      check_eq("db_no_wren", n_wren, 0);

      // LSU busy for 5 cycles while in RD.
      load_clean();
      do_reset(16'd0);
      scrub_en = 1'b1;
      wait_rd(6'h00, 20, ok);
      check_eq("busy_first_rd", ok, 1);
      repeat (2) @(posedge clk);
      #1 lsu_dccm_busy = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (scrub_dccm_rden) bad++;
      end
      check_eq("busy_no_rden", bad, 0);
      @(posedge clk);
      #1 lsu_dccm_busy = 1'b0;
      @(negedge clk);
      check_eq("busy_release_rden", scrub_dccm_rden, 1);
      check_eq("busy_release_addr", scrub_dccm_addr, 6'h04);

      // Single-bit error at 0x08 with an LSU write to 0x0A during CHK.
      load_clean();
      flip(2, 32'h0000_0100);
      do_reset(16'd0);
      scrub_en = 1'b1;
      wait_rd(6'h08, 40, ok);
      check_eq("coll_rd_seen", ok, 1);
      @(posedge clk);
      #1 begin lsu_dccm_wren = 1'b1; lsu_dccm_wr_addr = 6'h0A; end
      @(negedge clk);
      check_eq("coll_chk_wren", scrub_dccm_wren, 0);
      @(posedge clk);
      #1 lsu_dccm_wren = 1'b0;
      @(negedge clk);
      check_eq("coll_sb_pulse", scrub_sb_err, 1);
      check_eq("coll_err_addr", scrub_err_addr, 6'h08);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (scrub_dccm_rden) ok = 1'b1;
         else @(negedge clk);
      end
      check_eq("coll_next_rd_seen", ok, 1);
      check_eq("coll_next_addr", scrub_dccm_addr, 6'h0C);
      check_eq("coll_sb_cnt", scrub_sb_cnt, 1);
      check_eq("coll_no_wren", n_wren, 0);

      // Disable during WR, resume, then saturate the single-bit counter.
      load_clean();
      flip(1, 32'h0000_0001);
      flip(3, 32'h0000_0400);
      flip(5, 32'h0100_0000);
      flip(6, 32'h8000_0000);
      do_reset(16'd0);
      scrub_en = 1'b1;
      wait_rd(6'h04, 40, ok);
      check_eq("dis_rd_seen", ok, 1);
      @(posedge clk);
      @(posedge clk);
      #1 scrub_en = 1'b0;
      @(negedge clk);
      check_eq("dis_wr_completes", scrub_dccm_wren, 1);
      check_eq("dis_wr_addr", scrub_dccm_addr, 6'h04);
      n0 = rd_cyc.size();
      repeat (10) @(negedge clk);
      check_eq("dis_idle_no_rden", rd_cyc.size() - n0, 0);
      @(posedge clk);
      #1 begin
         force dut.sb_cnt_q = 16'hFFFE;
         scrub_en = 1'b1;
      end
      #1 release dut.sb_cnt_q;
      wait_rd(6'h08, 20, ok);
      check_eq("resume_next_word", ok, 1);
      k = 0;
      for (int i = 0; i < 200 && k < 3; i++) begin
         @(negedge clk);
         if (scrub_sb_err) k++;
      end
      check_eq("sat_three_errors", k, 3);
      check_eq("sat_sb_cnt", scrub_sb_cnt, 16'hFFFF);
      check_eq("sat_err_addr", scrub_err_addr, 6'h18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
